// File: rtl/dmem_pkg.sv
// dmem_pkg: definitions shared by the data-memory arbiter, the memory stage
// and the loader.
//   WORD_W              data/address width of both request ports
//   DMEM_POWER_DEFAULT  default log2 of the RAM depth in words
//   dmem_state_e        arbiter sequencing states
package dmem_pkg;

    localparam int unsigned WORD_W             = 32;
    localparam int unsigned DMEM_POWER_DEFAULT = 18;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CORE_RD = 2'd1,
        EXT_RD  = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the core port, the ext (loader/debug) port and
// the RAM macro port of the data-memory arbiter.
//   slave  modport: the arbiter's view (requests in, grants/data/RAM strobes out)
//   master modport: the environment's view (memory stage, loader, RAM macro)
// Parameter DMEM_POWER sets the width of ramAddr (log2 of RAM words).
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int unsigned DMEM_POWER = DMEM_POWER_DEFAULT
);

    logic                  coreReq;
    logic                  coreWe;
    logic [WORD_W-1:0]     coreAddr;
    logic [WORD_W-1:0]     coreWdata;
    logic [WORD_W-1:0]     coreRdata;
    logic                  coreRvalid;
    logic                  stallM;

    logic                  extReq;
    logic                  extWe;
    logic [WORD_W-1:0]     extAddr;
    logic [WORD_W-1:0]     extWdata;
    logic                  extGnt;
    logic [WORD_W-1:0]     extRdata;
    logic                  extRvalid;

    logic                  ramEn;
    logic                  ramWe;
    logic [DMEM_POWER-1:0] ramAddr;
    logic [WORD_W-1:0]     ramWdata;
    logic [WORD_W-1:0]     ramRdata;

    modport slave (
        input  coreReq, coreWe, coreAddr, coreWdata,
        output coreRdata, coreRvalid, stallM,
        input  extReq, extWe, extAddr, extWdata,
        output extGnt, extRdata, extRvalid,
        output ramEn, ramWe, ramAddr, ramWdata,
        input  ramRdata
    );

    modport master (
        output coreReq, coreWe, coreAddr, coreWdata,
        input  coreRdata, coreRvalid, stallM,
        output extReq, extWe, extAddr, extWdata,
        input  extGnt, extRdata, extRvalid,
        input  ramEn, ramWe, ramAddr, ramWdata,
        output ramRdata
    );

endinterface

// File: rtl/dmem_starve_cnt.sv
// dmem_starve_cnt: counts consecutive arbitrations lost by the ext port and
// flags when ext must be forced to win.
//   clk, reset  clock and synchronous active-high reset
//   lose        ext requested in IDLE and the core won
//   clear       ext was granted
//   force_ext   counter has reached LIMIT
module dmem_starve_cnt #(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic lose,
    input  logic clear,
    output logic force_ext
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (lose && (cnt != 4'hF)) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign force_ext = (cnt == 4'(LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port synchronous data RAM between the
// pipeline memory stage (core port) and the loader/debug port (ext port),
// sequences each access and drives the memory-stage stall.
//   clk, reset  clock and synchronous active-high reset
//   bus         dmem_arbiter_if.slave: core port, ext port and RAM port
// Parameters: DMEM_POWER (log2 RAM words), STARVE_LIMIT (1..15).
// Build option: define DMEM_ARB_FAIR_EN to let a starving ext port win after
// STARVE_LIMIT consecutive lost arbitrations; otherwise the core always wins.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DMEM_POWER   = DMEM_POWER_DEFAULT,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    dmem_arbiter_if.slave   bus
);

    localparam logic [3:0] STARVE_LIMIT_4 = 4'(STARVE_LIMIT);

    dmem_state_e       state;
    dmem_state_e       state_next;
    logic              issue_core;
    logic              issue_ext;
    logic              stall;
    logic              ext_force;
    logic [WORD_W-1:0] core_hold;
    logic [WORD_W-1:0] ext_hold;
    logic              core_ret;
    logic              ext_ret;

    // Byte-offset bits and bits above the RAM range are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.coreAddr, bus.extAddr};

`ifdef DMEM_ARB_FAIR_EN
    dmem_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk       (clk),
        .reset     (reset),
        .lose      ((state == IDLE) && bus.extReq && issue_core),
        .clear     (issue_ext),
        .force_ext (ext_force)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^STARVE_LIMIT_4;
    assign ext_force  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every combinational output is forced low while reset is high.
    always_comb begin
        state_next = state;
        issue_core = 1'b0;
        issue_ext  = 1'b0;
        stall      = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (bus.extReq && (ext_force || !bus.coreReq)) begin
                        issue_ext = 1'b1;
                        stall     = bus.coreReq;
                        if (!bus.extWe) begin
                            state_next = EXT_RD;
                        end
                    end else if (bus.coreReq) begin
                        issue_core = 1'b1;
                        if (!bus.coreWe) begin
                            stall      = 1'b1;
                            state_next = CORE_RD;
                        end
                    end
                end
                CORE_RD: begin
                    state_next = IDLE;
                end
                EXT_RD: begin
                    stall      = bus.coreReq;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.ramEn    = issue_core || issue_ext;
        bus.ramWe    = 1'b0;
        bus.ramAddr  = '0;
        bus.ramWdata = '0;
        if (issue_ext) begin
            bus.ramWe    = bus.extWe;
            bus.ramAddr  = bus.extAddr[DMEM_POWER+1:2];
            bus.ramWdata = bus.extWdata;
        end else if (issue_core) begin
            bus.ramWe    = bus.coreWe;
            bus.ramAddr  = bus.coreAddr[DMEM_POWER+1:2];
            bus.ramWdata = bus.coreWdata;
        end
    end

    assign bus.extGnt = issue_ext;
    assign bus.stallM = stall;

    // The return strobes come straight from the state register, gated by
    // reset so a read interrupted by reset never signals valid. Read data is
    // shown live from the RAM in the return cycle and held afterwards.
    assign core_ret = (state == CORE_RD) && !reset;
    assign ext_ret  = (state == EXT_RD) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            core_hold <= '0;
            ext_hold  <= '0;
        end else begin
            if (core_ret) begin
                core_hold <= bus.ramRdata;
            end
            if (ext_ret) begin
                ext_hold <= bus.ramRdata;
            end
        end
    end

    assign bus.coreRvalid = core_ret;
    assign bus.extRvalid  = ext_ret;
    assign bus.coreRdata  = core_ret ? bus.ramRdata : core_hold;
    assign bus.extRdata   = ext_ret ? bus.ramRdata : ext_hold;

endmodule
